// File: rtl/mir_skid_queue.sv
// Microinstruction register stage: a small FIFO between the control store and the datapath.
// It decodes the head entry into datapath control fields, and a flush discards the queue after a taken jump.
module mir_skid_queue #(
    parameter int REG_BUS_WIDTH       = 6,
    parameter int ALU_BUS_WIDTH       = 4,
    parameter int COND_BUS_WIDTH      = 3,
    parameter int JUMP_ADDR_BUS_WIDTH = 11,
    parameter int DEPTH               = 2,
    localparam int MIR_BUS_WIDTH = 3*REG_BUS_WIDTH + 5 + ALU_BUS_WIDTH
                                   + COND_BUS_WIDTH + JUMP_ADDR_BUS_WIDTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                           MIR_CLOCK_50,
    input  logic                           MIR_RESET_InLow,
    input  logic [MIR_BUS_WIDTH-1:0]       MIR_Microinstruccion_IN,
    input  logic                           MIR_IN_VALID,
    output logic                           MIR_IN_READY,
    input  logic                           MIR_OUT_READY,
    output logic                           MIR_OUT_VALID,
    input  logic                           MIR_FLUSH_InHigh,
    output logic [CNT_W-1:0]               MIR_COUNT_OUT,
    output logic [REG_BUS_WIDTH-1:0]       MIR_A_OUT,
    output logic [REG_BUS_WIDTH-1:0]       MIR_B_OUT,
    output logic [REG_BUS_WIDTH-1:0]       MIR_C_OUT,
    output logic                           MIR_AMUX_OUT,
    output logic                           MIR_BMUX_OUT,
    output logic                           MIR_CMUX_OUT,
    output logic                           MIR_RD_OUT,
    output logic                           MIR_WR_OUT,
    output logic [ALU_BUS_WIDTH-1:0]       MIR_ALU_OUT,
    output logic [COND_BUS_WIDTH-1:0]      MIR_COND_OUT,
    output logic [JUMP_ADDR_BUS_WIDTH-1:0] MIR_JUMP_ADDR_OUT
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [MIR_BUS_WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;
    logic                     push;
    logic                     pop;
    logic [MIR_BUS_WIDTH-1:0] head;

    // A full queue refuses new words even when the head is being popped in the same cycle.
    assign MIR_IN_READY  = (count < DEPTH_C) && !MIR_FLUSH_InHigh;
    assign MIR_OUT_VALID = (count != '0);
    assign MIR_COUNT_OUT = count;
    assign push          = MIR_IN_VALID && MIR_IN_READY;
    assign pop           = MIR_OUT_VALID && MIR_OUT_READY;

    always_ff @(negedge MIR_CLOCK_50 or negedge MIR_RESET_InLow) begin
        if (!MIR_RESET_InLow) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (MIR_FLUSH_InHigh) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= MIR_Microinstruccion_IN;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An empty queue presents an all-zero word, which the datapath treats as a NOP.
    assign head = MIR_OUT_VALID ? storage[rd_ptr] : '0;

    assign {MIR_A_OUT, MIR_AMUX_OUT, MIR_B_OUT, MIR_BMUX_OUT, MIR_C_OUT, MIR_CMUX_OUT,
            MIR_RD_OUT, MIR_WR_OUT, MIR_ALU_OUT, MIR_COND_OUT, MIR_JUMP_ADDR_OUT} = head;

endmodule

// File: tb/tb_mir_skid_queue.sv
// Self-checking bench for mir_skid_queue (default parameters, DEPTH=2).
// A queue-based reference model predicts the ready/valid/count/head behaviour.
module tb_mir_skid_queue;

    localparam int W     = 41;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_word;
    logic         in_valid;
    logic         in_ready;
    logic         out_ready;
    logic         out_valid;
    logic         flush;
    logic [1:0]   count;
    logic [5:0]   a_f, b_f, c_f;
    logic         amux_f, bmux_f, cmux_f, rd_f, wr_f;
    logic [3:0]   alu_f;
    logic [2:0]   cond_f;
    logic [10:0]  jump_f;

    mir_skid_queue dut (
        .MIR_CLOCK_50           (clk),
        .MIR_RESET_InLow        (rst_n),
        .MIR_Microinstruccion_IN(in_word),
        .MIR_IN_VALID           (in_valid),
        .MIR_IN_READY           (in_ready),
        .MIR_OUT_READY          (out_ready),
        .MIR_OUT_VALID          (out_valid),
        .MIR_FLUSH_InHigh       (flush),
        .MIR_COUNT_OUT          (count),
        .MIR_A_OUT              (a_f),
        .MIR_B_OUT              (b_f),
        .MIR_C_OUT              (c_f),
        .MIR_AMUX_OUT           (amux_f),
        .MIR_BMUX_OUT           (bmux_f),
        .MIR_CMUX_OUT           (cmux_f),
        .MIR_RD_OUT             (rd_f),
        .MIR_WR_OUT             (wr_f),
        .MIR_ALU_OUT            (alu_f),
        .MIR_COND_OUT           (cond_f),
        .MIR_JUMP_ADDR_OUT      (jump_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] dut_fields;
    assign dut_fields = {a_f, amux_f, b_f, bmux_f, c_f, cmux_f, rd_f, wr_f, alu_f, cond_f, jump_f};

    logic [W-1:0] model_q[$];
    int           vectors = 0;
    int           errors  = 0;
    logic         rdy_seen;
    logic         rdy_exp;

    function automatic logic [W-1:0] exp_head();
        return (model_q.size() != 0) ? model_q[0] : '0;
    endfunction

    // Drive one cycle: inputs held across the falling edge, outputs settle 1 ns after it.
    task automatic apply(input logic v, input logic [W-1:0] w, input logic ordy, input logic fl);
        logic do_push, do_pop;
        in_valid  = v;
        in_word   = w;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy_exp  = (model_q.size() < DEPTH) && !fl;
        rdy_seen = in_ready;
        do_push  = v && rdy_exp;
        do_pop   = (model_q.size() != 0) && ordy;
        @(negedge clk);
        if (fl) model_q.delete();
        else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(w);
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1'b1, 41'h0AAAAAAAAAA, 1'b0, 1'b0);
        apply(1'b1, 41'h15555555555, 1'b0, 1'b0);
        vectors++;
        if (count !== 2'd2) begin errors++; $display("FAIL reset_prefill count actual=%0d expected=2", count); end
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b expected=0", out_valid); end
        vectors++;
        if (count !== 2'd0) begin errors++; $display("FAIL reset_count actual=%0d expected=0", count); end
        vectors++;
        if (dut_fields !== '0) begin errors++; $display("FAIL reset_fields actual=%h expected=0", dut_fields); end
        #1 rst_n = 1'b1;
        in_valid = 1'b0; flush = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready actual=%b expected=1", in_ready); end
    endtask

    task automatic test_decode();
        logic [W-1:0] w;
        w = {6'd5, 1'b1, 6'd9, 1'b0, 6'd17, 1'b1, 1'b1, 1'b0, 4'hA, 3'd3, 11'h2F0};
        apply(1'b1, w, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL decode_valid actual=%b expected=1", out_valid); end
        vectors++;
        if ({a_f, amux_f, b_f, bmux_f, c_f, cmux_f, rd_f, wr_f} !== {6'd5, 1'b1, 6'd9, 1'b0, 6'd17, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL decode_regs actual A=%0d AMUX=%b B=%0d BMUX=%b C=%0d CMUX=%b RD=%b WR=%b expected 5 1 9 0 17 1 1 0",
                     a_f, amux_f, b_f, bmux_f, c_f, cmux_f, rd_f, wr_f);
        end
        vectors++;
        if ({alu_f, cond_f, jump_f} !== {4'hA, 3'd3, 11'h2F0}) begin
            errors++;
            $display("FAIL decode_ctl actual ALU=%h COND=%0d JUMP=%h expected A 3 2F0", alu_f, cond_f, jump_f);
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (count !== 2'd0) begin errors++; $display("FAIL decode_drain count actual=%0d expected=0", count); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w0, w1, w2;
        w0 = 41'h00000000101; w1 = 41'h00000000202; w2 = 41'h00000000303;
        apply(1'b1, w0, 1'b0, 1'b0);
        apply(1'b1, w1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready actual=%b expected=0", in_ready); end
        vectors++;
        if (count !== 2'd2) begin errors++; $display("FAIL bp_full_count actual=%0d expected=2", count); end
        apply(1'b1, w2, 1'b0, 1'b0);
        vectors++;
        if (dut_fields !== w0 || count !== 2'd2) begin
            errors++; $display("FAIL bp_hold actual head=%h count=%0d expected head=%h count=2", dut_fields, count, w0);
        end
        // Full queue with pop: W2 must still be refused this cycle.
        apply(1'b1, w2, 1'b1, 1'b0);
        vectors++;
        if (rdy_seen !== 1'b0) begin errors++; $display("FAIL fullpop_ready actual=%b expected=0", rdy_seen); end
        vectors++;
        if (count !== 2'd1 || dut_fields !== w1) begin
            errors++; $display("FAIL fullpop_state actual head=%h count=%0d expected head=%h count=1", dut_fields, count, w1);
        end
        apply(1'b1, w2, 1'b1, 1'b0);
        vectors++;
        if (count !== 2'd1 || dut_fields !== w2) begin
            errors++; $display("FAIL bp_w2 actual head=%h count=%0d expected head=%h count=1", dut_fields, count, w2);
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || dut_fields !== '0) begin
            errors++; $display("FAIL bp_empty actual valid=%b head=%h expected valid=0 head=0", out_valid, dut_fields);
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (count !== 2'd0) begin errors++; $display("FAIL underflow count actual=%0d expected=0", count); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] ws[8];
        for (int i = 0; i < 8; i++) ws[i] = {$urandom(), 9'(i + 1)};
        apply(1'b1, ws[0], 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            apply(1'b1, ws[k], 1'b1, 1'b0);
            vectors++;
            if (count !== 2'd1 || dut_fields !== ws[k]) begin
                errors++;
                $display("FAIL wrap_%0d actual head=%h count=%0d expected head=%h count=1", k, dut_fields, count, ws[k]);
            end
        end
        apply(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        apply(1'b1, 41'h00000000AA1, 1'b0, 1'b0);
        apply(1'b1, 41'h00000000AA2, 1'b0, 1'b0);
        apply(1'b1, 41'h1FFFFFFFFFF, 1'b0, 1'b1);
        vectors++;
        if (rdy_seen !== 1'b0) begin errors++; $display("FAIL flush_ready actual=%b expected=0", rdy_seen); end
        vectors++;
        if (count !== 2'd0 || out_valid !== 1'b0 || dut_fields !== '0) begin
            errors++; $display("FAIL flush_state actual count=%0d valid=%b head=%h expected 0 0 0", count, out_valid, dut_fields);
        end
        apply(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || dut_fields !== '0) begin
            errors++; $display("FAIL flush_dropped actual valid=%b head=%h expected 0 0", out_valid, dut_fields);
        end
        // Pointers restart at 0 after flush: two pushes then in-order reads.
        apply(1'b1, 41'h00000000BB1, 1'b0, 1'b0);
        apply(1'b1, 41'h00000000BB2, 1'b1, 1'b0);
        vectors++;
        if (dut_fields !== 41'h00000000BB2 || count !== 2'd1) begin
            errors++; $display("FAIL flush_restart actual head=%h count=%0d expected head=00000000bb2 count=1", dut_fields, count);
        end
        apply(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        for (int i = 0; i < 300; i++) begin
            w = {$urandom(), 9'($urandom())};
            apply(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
            vectors++;
            if (rdy_seen !== rdy_exp) begin
                errors++; $display("FAIL rand_ready[%0d] actual=%b expected=%b", i, rdy_seen, rdy_exp);
            end
            vectors++;
            if (count !== 2'(model_q.size()) || out_valid !== (model_q.size() != 0) || dut_fields !== exp_head()) begin
                errors++;
                $display("FAIL rand_state[%0d] actual count=%0d valid=%b head=%h expected count=%0d head=%h",
                         i, count, out_valid, dut_fields, model_q.size(), exp_head());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; flush = 1'b0;
        #13 rst_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || count !== 2'd0 || dut_fields !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL initial actual valid=%b count=%0d head=%h ready=%b expected 0 0 0 1",
                               out_valid, count, dut_fields, in_ready);
        end
        test_reset();
        test_decode();
        test_backpressure();
        test_wrap();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
